reg_bank: RTL and testbench
===========================

Name: reg_bank

Overview:
- 32-entry general-purpose register bank for the 5-stage pipeline.
- Decode reads two source operands from it. Writeback writes one result into it per cycle.
- It is the consuming end of the writeback path that the forwarding unit snoops.
- Read data is registered and feeds the forwarding unit's id_fw_rega/id_fw_regb inputs one cycle after the address is presented.

Parameters:
- WIDTH, 32, data width of each register
- NREGS, 32, number of registers; addresses are 5 bits
- SP_INIT, 32'h000003FC, reset value of register 29 (stack pointer)

Ports:
- clock  input  1  system clock; all state updates on posedge
- reset  input  1  asynchronous, active-low; 0 clears state immediately
- id_rf_addra  input  5  Decode source address A
- id_rf_addrb  input  5  Decode source address B
- id_rf_enable  input  1  1 = capture new read; 0 = hold outputs (pipeline stall)
- rf_id_rega  output  WIDTH  registered read data A
- rf_id_regb  output  WIDTH  registered read data B
- wb_rf_writereg  input  1  Writeback write enable
- wb_rf_writeaddr  input  5  Writeback destination register
- wb_rf_writedata  input  WIDTH  Writeback data
- rf_writecount  output  16  number of committed writes since reset; debug

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers clear to 0, except reg 29, which takes SP_INIT.
  - rf_id_rega, rf_id_regb and rf_writecount clear to 0.
  - Takes effect immediately, including mid-operation. Any write in flight on the same edge is discarded.
  - After reset deasserts, the first posedge operates normally.
- Write:
  - On posedge with wb_rf_writereg=1 and wb_rf_writeaddr!=0: reg[addr] <= wb_rf_writedata, and rf_writecount increments.
  - Writes to address 0 are ignored and do not count.
  - rf_writecount wraps from 16'hFFFF to 0.
- Read:
  - On posedge with id_rf_enable=1, rf_id_rega <= value(id_rf_addra) and rf_id_regb <= value(id_rf_addrb). Latency is 1 cycle.
  - Address 0 always returns 0.
  - With id_rf_enable=0, both outputs hold their previous values regardless of addresses or writes.
- Write-through bypass:
  - When the same posedge carries a read and a valid write to the same nonzero address, the read returns wb_rf_writedata, not the old contents.
  - Applies independently to ports A and B. Both ports may read the written address simultaneously.
- A read of address 0 while a write targets address 0 returns 0.
- Held outputs (id_rf_enable=0) are not refreshed by a later write to the held address. Freshness of stalled operands is the forwarding unit's responsibility.
- No combinational path from any input to any output.
- Storage is a register array. Writes are single-ported and reads dual-ported; no arbitration is needed.

Test Plan:
1. Reset value: pulse reset low with no writes, then read A=29, B=0 → rega=000003FC, regb=00000000; rf_writecount=0.
2. Write then read: write reg5=DEADBEEF. Next cycle read A=5, B=5 → both read DEADBEEF, appearing exactly 1 posedge after the read address edge. rf_writecount=1.
3. Same-cycle bypass: in one cycle, write reg6=12345678 while reading A=6, B=3 (reg3=0) → rega=12345678, regb=0.
4. Register zero: write reg0=FFFFFFFF, then read A=0 → rega=0, with the bypass case included. rf_writecount unchanged.
5. Stall hold:
   - Read A=5 (DEADBEEF), then drop id_rf_enable for 3 cycles.
   - Meanwhile write reg5=CAFEF00D and change addresses → rega stays DEADBEEF.
   - On re-enable with A=5 → rega=CAFEF00D.
6. Async reset mid-operation: assert reset between clock edges with a write pending → outputs go to 0 immediately without a posedge. A later read of the pending register returns 0, or SP_INIT for reg 29.

Source files
------------

// File: rtl/reg_bank.sv
// 32-entry general-purpose register bank with registered dual read ports,
// one writeback write port, write-through bypass and a debug write counter.
module reg_bank #(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      NREGS   = 32,
  parameter logic [WIDTH-1:0] SP_INIT = 32'h000003FC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rf_addra,
  input  logic [4:0]       id_rf_addrb,
  input  logic             id_rf_enable,
  output logic [WIDTH-1:0] rf_id_rega,
  output logic [WIDTH-1:0] rf_id_regb,
  input  logic             wb_rf_writereg,
  input  logic [4:0]       wb_rf_writeaddr,
  input  logic [WIDTH-1:0] wb_rf_writedata,
  output logic [15:0]      rf_writecount
);

  localparam int unsigned SP_IDX = 29;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] rega_q, rega_d;
  logic [WIDTH-1:0] regb_q, regb_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             wr_en;

  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    rega_d = rega_q;
    regb_d = regb_q;
    wr_en  = wb_rf_writereg && (wb_rf_writeaddr != 5'd0);

    if (wr_en) begin
      regs_d[wb_rf_writeaddr] = wb_rf_writedata;
      cnt_d                   = cnt_q + 16'd1;
    end

    // Reads index the post-write array, so a same-edge write is seen by both ports.
    if (id_rf_enable) begin
      rega_d = (id_rf_addra == 5'd0) ? '0 : regs_d[id_rf_addra];
      regb_d = (id_rf_addrb == 5'd0) ? '0 : regs_d[id_rf_addrb];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
      rega_q <= '0;
      regb_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      rega_q <= rega_d;
      regb_q <= regb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rf_id_rega    = rega_q;
  assign rf_id_regb    = regb_q;
  assign rf_writecount = cnt_q;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: table-driven vectors through a scoreboard
// queue, plus hand-written async-reset and write-counter wrap sequences.
module tb_reg_bank;

  logic        clock;
  logic        reset;
  logic [4:0]  id_rf_addra;
  logic [4:0]  id_rf_addrb;
  logic        id_rf_enable;
  logic [31:0] rf_id_rega;
  logic [31:0] rf_id_regb;
  logic        wb_rf_writereg;
  logic [4:0]  wb_rf_writeaddr;
  logic [31:0] wb_rf_writedata;
  logic [15:0] rf_writecount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic [4:0]  a;
    logic [4:0]  b;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [15:0] ec;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] c;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];

  reg_bank #(
    .WIDTH  (32),
    .NREGS  (32),
    .SP_INIT(32'h000003FC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .id_rf_addra    (id_rf_addra),
    .id_rf_addrb    (id_rf_addrb),
    .id_rf_enable   (id_rf_enable),
    .rf_id_rega     (rf_id_rega),
    .rf_id_regb     (rf_id_regb),
    .wb_rf_writereg (wb_rf_writereg),
    .wb_rf_writeaddr(wb_rf_writeaddr),
    .wb_rf_writedata(wb_rf_writedata),
    .rf_writecount  (rf_writecount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rf_enable    = v.en;
    id_rf_addra     = v.a;
    id_rf_addrb     = v.b;
    wb_rf_writereg  = v.we;
    wb_rf_writeaddr = v.wa;
    wb_rf_writedata = v.wd;
  endtask

  // Drive one vector across a posedge and compare the popped expectation #1 later.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    drive(v);
    sb.push_back('{v.ea, v.eb, v.ec});
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".rega"}, rf_id_rega, e.a);
      check({tag, ".regb"}, rf_id_regb, e.b);
      check({tag, ".cnt"}, {16'h0, rf_writecount}, {16'h0, e.c});
    end
  endtask

  initial begin
    vec_t v;
    //          en  a   b   we  wa  wd            ea            eb            ec
    vecs[0]  = '{1, 29,  0, 0,  0, 32'h0,        32'h000003FC, 32'h0,        16'd0};
    vecs[1]  = '{1,  1,  2, 1,  5, 32'hDEADBEEF, 32'h0,        32'h0,        16'd1};
    vecs[2]  = '{1,  5,  5, 0,  0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
    vecs[3]  = '{1,  6,  3, 1,  6, 32'h12345678, 32'h12345678, 32'h0,        16'd2};
    vecs[4]  = '{1,  7,  7, 1,  7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 16'd3};
    vecs[5]  = '{1,  0,  6, 1,  0, 32'hFFFFFFFF, 32'h0,        32'h12345678, 16'd3};
    vecs[6]  = '{1,  0,  0, 0,  0, 32'h0,        32'h0,        32'h0,        16'd3};
    vecs[7]  = '{1,  5,  7, 0,  0, 32'h0,        32'hDEADBEEF, 32'hA5A5A5A5, 16'd3};
    vecs[8]  = '{0,  6,  0, 1,  5, 32'hCAFEF00D, 32'hDEADBEEF, 32'hA5A5A5A5, 16'd4};
    vecs[9]  = '{0,  1,  2, 0,  0, 32'h0,        32'hDEADBEEF, 32'hA5A5A5A5, 16'd4};
    vecs[10] = '{0,  5,  7, 1,  7, 32'h11112222, 32'hDEADBEEF, 32'hA5A5A5A5, 16'd5};
    vecs[11] = '{1,  5,  7, 0,  0, 32'h0,        32'hCAFEF00D, 32'h11112222, 16'd5};
    vecs[12] = '{1, 31, 29, 1, 31, 32'h80000001, 32'h80000001, 32'h000003FC, 16'd6};
    vecs[13] = '{1, 29, 30, 1, 29, 32'h00001000, 32'h00001000, 32'h0,        16'd7};

    reset = 1'b0;
    drive('{0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 16'd0});
    #3;
    check("por.rega", rf_id_rega, 32'h0);
    check("por.regb", rf_id_regb, 32'h0);
    check("por.cnt", {16'h0, rf_writecount}, 32'h0);
    @(posedge clock);
    #2;
    reset = 1'b1;

    for (int i = 0; i < 14; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Async reset between edges with a write to r9 pending on the inputs.
    drive('{1, 9, 29, 1, 9, 32'h00000099, 32'h0, 32'h0, 16'd0});
    #2;
    reset = 1'b0;
    #1;
    check("arst.rega", rf_id_rega, 32'h0);
    check("arst.regb", rf_id_regb, 32'h0);
    check("arst.cnt", {16'h0, rf_writecount}, 32'h0);
    @(posedge clock);
    #1;
    check("arst_hold.rega", rf_id_rega, 32'h0);
    check("arst_hold.cnt", {16'h0, rf_writecount}, 32'h0);
    reset = 1'b1;
    apply('{1, 9, 29, 0, 0, 32'h0, 32'h0, 32'h000003FC, 16'd0}, "post_rst_a");
    apply('{1, 5, 31, 0, 0, 32'h0, 32'h0, 32'h0, 16'd0}, "post_rst_b");

    // Counter wrap: 65535 counted writes, then one more rolls to zero.
    for (int i = 0; i < 65535; i++) begin
      drive('{0, 0, 0, 1, 1, i, 32'h0, 32'h0, 16'd0});
      @(posedge clock);
      #1;
    end
    check("wrap.ffff", {16'h0, rf_writecount}, 32'h0000FFFF);
    v = '{1, 1, 0, 1, 1, 32'h0BADF00D, 32'h0BADF00D, 32'h0, 16'd0};
    apply(v, "wrap.zero");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
